// File: rtl/act_sram_stream_reader.sv
// Strided read client for one activation SRAM port; returned words are
// captured in a 2-entry FIFO and presented as a valid/ready stream.
module act_sram_stream_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_wea,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [1:0]       L_DEPTH = 2'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] L_ONE   = LEN_W'(1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_popped;
  logic [DATA_W-1:0] r_mem [2];

  logic              w_start_ok;
  logic              w_first;
  logic              w_run_issue;
  logic              w_issue;
  logic              w_pop;
  logic              w_room;
  logic              w_head_last;
  logic              w_last_pop;
  logic [1:0]        w_occ;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [ADDR_W-1:0] w_step;

  // Occupancy counts the word still on its way back from the SRAM.
  assign w_occ   = r_cnt + {1'b0, r_inflight};
  assign w_pop   = (r_cnt != 2'd0) & m_ready;
  assign w_room  = (w_occ < L_DEPTH) |
                   ((w_occ == L_DEPTH) & w_pop);

  assign w_start_ok  = start & ~abort &
                       (r_state == S_IDLE);
  // The first read goes out in the start cycle itself.
  assign w_first     = w_start_ok & (cfg_len != '0);
  assign w_run_issue = (r_state == S_RUN) & ~abort &
                       (r_issued != r_len) & w_room;
  assign w_issue     = w_first | w_run_issue;

  assign w_issue_addr = w_first ? cfg_base : r_next_addr;
  assign w_step       = w_first ? cfg_stride : r_stride;

  assign w_head_last = (r_popped == r_len - L_ONE);
  assign w_last_pop  = w_pop & w_head_last;

  assign sram_addr  = w_issue ? w_issue_addr : r_addr;
  assign sram_wea   = 4'b0000;
  assign sram_wdata = '0;

  assign busy    = r_busy;
  assign done    = r_done;
  assign m_valid = (r_cnt != 2'd0);
  assign m_data  = r_mem[r_rd_ptr];
  assign m_last  = m_valid & w_head_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_inflight <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
        r_cnt      <= 2'd0;
        r_issued   <= '0;
        r_popped   <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_addr      <= w_issue_addr;
          r_next_addr <= w_issue_addr + w_step;
          r_issued    <= w_first ? L_ONE
                                 : r_issued + L_ONE;
        end

        if (r_inflight) begin
          r_mem[r_wr_ptr] <= sram_rdata;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
          r_popped <= r_popped + L_ONE;
        end
        r_cnt <= r_cnt + {1'b0, r_inflight}
                       - {1'b0, w_pop};

        unique case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_stride <= cfg_stride;
              r_len    <= cfg_len;
              r_popped <= '0;
              if (cfg_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_last_pop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_issued == r_len) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_last_pop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_act_sram_stream_reader.sv
// Bench for act_sram_stream_reader: SRAM model plus a queue-free
// reference computed from base + k*stride arithmetic.
module tb_act_sram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [11:0] cfg_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] sram_addr;
  logic [3:0]  sram_wea;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:65535];

  act_sram_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_len    (cfg_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .sram_addr  (sram_addr),
    .sram_wea   (sram_wea),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_rdata <= mem[sram_addr];

  int          obs_n;
  int          obs_first;
  int          obs_last_pop;
  int          obs_done_cyc;
  int          obs_done_cnt;
  int          obs_stall_bad;
  int          obs_ovf;
  int          obs_wr;
  logic        obs_busy1;
  logic        obs_busy_done;
  logic [31:0] obs_data [0:63];
  logic        obs_last [0:63];

  function automatic logic [31:0] ref_word(
    input logic [15:0] b, input logic [15:0] s, input int k);
    int a;
    a = (int'(b) + k * int'(s)) % 65536;
    return mem[a];
  endfunction

  task automatic kick(input logic [15:0] b, input logic [15:0] s,
                      input logic [11:0] n);
    @(negedge clk);
    cfg_base   = b;
    cfg_stride = s;
    cfg_len    = n;
    start      = 1'b1;
  endtask

  // Records what the stream does; the tests judge it.
  task automatic collect(input int mode, input int budget);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [5:0]  pat;
    prev_stall = 1'b0;
    prev_data  = '0;
    pat = 6'b101001;
    obs_n = 0; obs_first = -1; obs_last_pop = -1;
    obs_done_cyc = -1; obs_done_cnt = 0;
    obs_stall_bad = 0; obs_ovf = 0; obs_wr = 0;
    obs_busy1 = 1'b0; obs_busy_done = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = pat[(cyc - 1) % 6];
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
      if (cyc == 1) obs_busy1 = busy;
      if (sram_wea !== 4'b0 || sram_wdata !== 32'b0) obs_wr++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data))
        obs_stall_bad++;
      if (dut.r_inflight && dut.r_cnt == 2'd2 && !(m_valid && m_ready))
        obs_ovf++;
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc  = cyc;
          obs_busy_done = busy;
        end
      end
      if (m_valid === 1'b1 && obs_first < 0) obs_first = cyc;
      if (m_valid === 1'b1 && m_ready) begin
        if (obs_n < 64) begin
          obs_data[obs_n] = m_data;
          obs_last[obs_n] = m_last;
        end
        obs_n++;
        obs_last_pop = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 2) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, m_valid, m_last});
    end
    checks++;
    if (m_data !== 32'h0 || sram_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0", m_data, sram_addr);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = 32'hA000_0000 + i;
    kick(16'h0010, 16'h0001, 12'd8);
    collect(0, 40);
    checks++;
    if (obs_n !== 8) begin
      errors++; $display("FAIL basic_count got %0d want 8", obs_n);
    end
    for (int i = 0; i < 8 && i < obs_n; i++) begin
      checks++;
      if (obs_data[i] !== 32'hA000_0000 + i) begin
        errors++;
        $display("FAIL basic_data[%0d] got %h want %h",
                 i, obs_data[i], 32'hA000_0000 + i);
      end
      checks++;
      if (obs_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL basic_last[%0d] got %b want %b", i, obs_last[i], i == 7);
      end
    end
    checks++;
    if (obs_first !== 2) begin
      errors++; $display("FAIL basic_latency got %0d want 2", obs_first);
    end
    checks++;
    if (obs_last_pop - obs_first !== 7) begin
      errors++;
      $display("FAIL basic_rate got %0d want 7", obs_last_pop - obs_first);
    end
    checks++;
    if (obs_done_cyc !== obs_last_pop + 1 || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done got %0d/%0d want %0d/1",
               obs_done_cyc, obs_done_cnt, obs_last_pop + 1);
    end
    checks++;
    if (obs_busy1 !== 1'b1 || obs_busy_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got %b%b want 10", obs_busy1, obs_busy_done);
    end
    checks++;
    if (obs_wr !== 0) begin
      errors++; $display("FAIL basic_wea got %0d want 0", obs_wr);
    end
  endtask

  task automatic test_stride_wrap;
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'h0001, 16'h0004, 16'h0007};
    for (int i = 0; i < 4; i++) mem[exp_a[i]] = {16'h5A5A, exp_a[i]};
    kick(16'hFFFE, 16'h0003, 12'd4);
    collect(0, 30);
    checks++;
    if (obs_n !== 4) begin
      errors++; $display("FAIL wrap_count got %0d want 4", obs_n);
    end
    for (int i = 0; i < 4 && i < obs_n; i++) begin
      checks++;
      if (obs_data[i] !== {16'h5A5A, exp_a[i]}) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got %h want %h",
                 i, obs_data[i], {16'h5A5A, exp_a[i]});
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] b;
    logic [15:0] s;
    b = 16'($urandom);
    s = 16'($urandom);
    kick(b, s, 12'd6);
    collect(1, 60);
    checks++;
    if (obs_n !== 6) begin
      errors++; $display("FAIL bp_count got %0d want 6", obs_n);
    end
    for (int i = 0; i < 6 && i < obs_n; i++) begin
      checks++;
      if (obs_data[i] !== ref_word(b, s, i) || obs_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL bp_data[%0d] got %h/%b want %h/%b", i,
                 obs_data[i], obs_last[i], ref_word(b, s, i), i == 5);
      end
    end
    checks++;
    if (obs_stall_bad !== 0 || obs_ovf !== 0) begin
      errors++;
      $display("FAIL bp_hold_ovf got %0d/%0d want 0/0",
               obs_stall_bad, obs_ovf);
    end
    checks++;
    if (obs_done_cyc !== obs_last_pop + 1) begin
      errors++;
      $display("FAIL bp_done got %0d want %0d", obs_done_cyc, obs_last_pop + 1);
    end
  endtask

  task automatic test_zero_len;
    logic [15:0] a0;
    a0 = sram_addr;
    kick(16'hBEEF, 16'h0001, 12'd0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      checks++;
      if (done !== (cyc == 1) || busy !== 1'b0 || sram_addr !== a0) begin
        errors++;
        $display("FAIL zero_len[%0d] got %b%b/%h want %b0/%h",
                 cyc, done, busy, sram_addr, cyc == 1, a0);
      end
    end
  endtask

  task automatic test_abort;
    m_ready = 1'b0;
    kick(16'h0040, 16'h0001, 12'd8);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got %b%b want 11", m_valid, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_post got %b%b%b want 000", m_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet got %b%b want 00", done, m_valid);
      end
    end
    kick(16'h0020, 16'h0001, 12'd2);
    collect(0, 20);
    checks++;
    if (obs_n !== 2 || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_follow got %0d/%0d want 2/1", obs_n, obs_done_cnt);
    end
    for (int i = 0; i < 2 && i < obs_n; i++) begin
      checks++;
      if (obs_data[i] !== mem[16'h20 + i] || obs_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL abort_data[%0d] got %h want %h",
                 i, obs_data[i], mem[16'h20 + i]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] b;
    m_ready = 1'b1;
    kick(16'h0100, 16'h0001, 12'd10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0 ||
        m_data !== 32'h0 || sram_addr !== 16'h0) begin
      errors++;
      $display("FAIL async_rst got %b%b%b%b/%h/%h want 0000/0/0",
               busy, done, m_valid, m_last, m_data, sram_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL async_quiet got %b%b want 00", done, m_valid);
      end
    end
    b = 16'($urandom);
    kick(b, 16'h0002, 12'd5);
    collect(0, 30);
    checks++;
    if (obs_n !== 5 || obs_done_cyc !== obs_last_pop + 1) begin
      errors++;
      $display("FAIL async_after got %0d/%0d want 5/%0d",
               obs_n, obs_done_cyc, obs_last_pop + 1);
    end
    for (int i = 0; i < 5 && i < obs_n; i++) begin
      checks++;
      if (obs_data[i] !== ref_word(b, 16'h0002, i)) begin
        errors++;
        $display("FAIL async_data[%0d] got %h want %h",
                 i, obs_data[i], ref_word(b, 16'h0002, i));
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] b;
    logic [15:0] s;
    int          n;
    for (int t = 0; t < 6; t++) begin
      b = 16'($urandom);
      s = 16'($urandom);
      n = $urandom_range(1, 16);
      kick(b, s, 12'(n));
      collect(2, 40 + n * 12);
      checks++;
      if (obs_n !== n || obs_done_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_count got %0d/%0d want %0d/1",
                 t, obs_n, obs_done_cnt, n);
      end
      for (int i = 0; i < n && i < obs_n; i++) begin
        checks++;
        if (obs_data[i] !== ref_word(b, s, i) ||
            obs_last[i] !== (i == n - 1)) begin
          errors++;
          $display("FAIL rand%0d_data[%0d] got %h/%b want %h/%b", t, i,
                   obs_data[i], obs_last[i], ref_word(b, s, i), i == n - 1);
        end
      end
      checks++;
      if (obs_stall_bad !== 0 || obs_ovf !== 0 || obs_busy_done !== 1'b0 ||
          obs_done_cyc !== obs_last_pop + 1) begin
        errors++;
        $display("FAIL rand%0d_ctl got %0d/%0d/%b/%0d want 0/0/0/%0d", t,
                 obs_stall_bad, obs_ovf, obs_busy_done,
                 obs_done_cyc, obs_last_pop + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    m_ready    = 1'b0;
    cfg_base   = '0;
    cfg_stride = '0;
    cfg_len    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_basic;
    test_stride_wrap;
    test_backpressure;
    test_zero_len;
    test_abort;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
